// File: rtl/honzales_raster.sv
// honzales_raster
// Raster-scan test-pattern source. It emits one WIDTH x HEIGHT frame in
// row-major order. Each pixel goes out as three OUT_W-bit beats (R, G, B)
// over a valid/ready stream.
//
// Ports:
//   clock        rising-edge clock
//   resetb       asynchronous active-low reset
//   enable       run request, sampled only at frame boundaries
//   clear        synchronous abort back to IDLE (frame_count held)
//   mode         pattern select, latched at frame start
//   pix_ready    sink ready
//   pix_valid    beat valid
//   pix_data     component value (R, G, then B)
//   sof          first beat of pixel (0,0)
//   eol          B beat of the last pixel in a line
//   eof          B beat of the last pixel in the frame
//   busy         high while in STREAM
//   frame_count  completed frames, wrapping
module honzales_raster #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int OUT_W  = 8,
    parameter int FCNT_W = 16
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              enable,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic              pix_ready,
    output logic              pix_valid,
    output logic [OUT_W-1:0]  pix_data,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int SX = OUT_W - XW;
    localparam int SY = OUT_W - YW;
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [1:0]          comp_q, comp_d;
    logic                valid_q, valid_d;
    logic [OUT_W-1:0]    data_q, data_d;
    logic                sof_q, sof_d;
    logic                eol_q, eol_d;
    logic                eof_q, eof_d;
    logic                busy_q, busy_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                present;
    logic                xfer;

    // Component value of the pattern at pixel (px,py) for component c.
    function automatic logic [OUT_W-1:0] pattern(input logic [1:0] m,
                                                 input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py,
                                                 input logic [1:0] c);
        logic [OUT_W-1:0] v;
        v = '0;
        case (m)
            2'd0: if (c == 2'd0) v = '1;
            2'd1: if (c == 2'd0) v = OUT_W'(px) << SX;
            2'd2: if (c == 2'd1) v = OUT_W'(py) << SY;
            default: if (px[3] ^ py[3]) v = '1;
        endcase
        return v;
    endfunction

    assign xfer = valid_q & pix_ready;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        comp_d  = comp_q;
        fcnt_d  = fcnt_q;
        present = 1'b0;

        if (clear) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            comp_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        // Arm cycle: the sof beat is presented one cycle later.
                        state_d = STREAM;
                        mode_d  = mode;
                        x_d     = '0;
                        y_d     = '0;
                        comp_d  = '0;
                    end
                end
                default: begin
                    if (!valid_q) begin
                        present = 1'b1;
                    end else if (xfer) begin
                        if (eof_q) begin
                            fcnt_d = fcnt_q + 1'b1;
                            x_d    = '0;
                            y_d    = '0;
                            comp_d = '0;
                            if (enable) begin
                                // Back-to-back frame: no bubble after eof.
                                mode_d  = mode;
                                present = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            present = 1'b1;
                            if (comp_q == 2'd2) begin
                                comp_d = '0;
                                if (x_q == XMAX) begin
                                    x_d = '0;
                                    y_d = y_q + 1'b1;
                                end else begin
                                    x_d = x_q + 1'b1;
                                end
                            end else begin
                                comp_d = comp_q + 1'b1;
                            end
                        end
                    end else begin
                        // Stalled: counters unchanged, so outputs recompute identically.
                        present = 1'b1;
                    end
                end
            endcase
        end

        valid_d = present;
        busy_d  = (state_d == STREAM);
        data_d  = '0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        eof_d   = 1'b0;
        if (present) begin
            data_d = pattern(mode_d, x_d, y_d, comp_d);
            sof_d  = (x_d == '0) && (y_d == '0) && (comp_d == 2'd0);
            eol_d  = (comp_d == 2'd2) && (x_d == XMAX);
            eof_d  = (comp_d == 2'd2) && (x_d == XMAX) && (y_d == YMAX);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            mode_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            comp_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            comp_q  <= comp_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign pix_valid   = valid_q;
    assign pix_data    = data_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign eof         = eof_q;
    assign busy        = busy_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_honzales_raster.sv
// Testbench for honzales_raster. The main instance uses the default 64x64
// geometry. A second 16x16 instance with a 2-bit frame counter exercises
// counter wrap.
module tb_honzales_raster;

    localparam int W     = 64;
    localparam int H     = 64;
    localparam int OW    = 8;
    localparam int FW    = 16;
    localparam int FRAME = 3 * W * H;
    localparam int MAXV  = (1 << OW) - 1;

    logic          clock = 1'b0;
    logic          resetb;
    logic          enable;
    logic          clear;
    logic [1:0]    mode;
    logic          pix_ready;
    logic          pix_valid;
    logic [OW-1:0] pix_data;
    logic          sof, eol, eof, busy;
    logic [FW-1:0] frame_count;

    logic          w_resetb, w_en, w_clear, w_ready;
    logic [1:0]    w_mode;
    logic          w_valid, w_sof, w_eol, w_eof, w_busy;
    logic [OW-1:0] w_data;
    logic [1:0]    w_fc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    honzales_raster #(.WIDTH(W), .HEIGHT(H), .OUT_W(OW), .FCNT_W(FW)) u_dut (
        .clock(clock), .resetb(resetb), .enable(enable), .clear(clear),
        .mode(mode), .pix_ready(pix_ready), .pix_valid(pix_valid),
        .pix_data(pix_data), .sof(sof), .eol(eol), .eof(eof), .busy(busy),
        .frame_count(frame_count)
    );

    honzales_raster #(.WIDTH(16), .HEIGHT(16), .OUT_W(OW), .FCNT_W(2)) u_wrap (
        .clock(clock), .resetb(w_resetb), .enable(w_en), .clear(w_clear),
        .mode(w_mode), .pix_ready(w_ready), .pix_valid(w_valid),
        .pix_data(w_data), .sof(w_sof), .eol(w_eol), .eof(w_eof), .busy(w_busy),
        .frame_count(w_fc)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: expected beat k of a frame in pattern m.
    function automatic int ref_beat(input int m, input int k, output bit s, output bit el, output bit ef);
        int p, c, x, y, d;
        p = k / 3;
        c = k % 3;
        x = p % W;
        y = p / W;
        d = 0;
        case (m)
            0: d = (c == 0) ? MAXV : 0;
            1: d = (c == 0) ? x * ((1 << OW) / W) : 0;
            2: d = (c == 1) ? y * ((1 << OW) / H) : 0;
            default: d = (((x / 8) % 2) != ((y / 8) % 2)) ? MAXV : 0;
        endcase
        s  = (k == 0);
        el = (c == 2) && (x == W - 1);
        ef = (k == FRAME - 1);
        return d;
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the edge
    // where the sof beat should be presented.
    task automatic start_frame(input logic [1:0] m, input logic en_after);
        enable = 1'b1;
        mode   = m;
        @(posedge clock); #1;
        check_eq("start_lat_valid", pix_valid, 0);
        check_eq("start_busy", busy, 1);
        enable = en_after;
        mode   = 2'($urandom_range(3));
        @(posedge clock); #1;
    endtask

    // Consumes a frame beat by beat against the model. sw_beat changes
    // enable/mode mid-frame; abort_beat asserts clear with a transfer.
    task automatic stream_frame(input int exp_mode, input int ready_pct, input int sw_beat,
                                input logic en_sw, input logic [1:0] mode_sw,
                                input int abort_beat, output int nbeats);
        int  k;
        int  cyc;
        int  d;
        bit  s, el, ef;
        logic rdy;
        k   = 0;
        cyc = 0;
        while (k < FRAME && cyc < 4 * FRAME) begin
            d = ref_beat(exp_mode, k, s, el, ef);
            check_eq("valid", pix_valid, 1);
            check_eq("data", pix_data, d);
            check_eq("sof", sof, s);
            check_eq("eol", eol, el);
            check_eq("eof", eof, ef);
            if (k == sw_beat) begin
                enable = en_sw;
                mode   = mode_sw;
            end
            if (k == abort_beat) begin
                pix_ready = 1'b1;
                clear     = 1'b1;
                @(posedge clock); #1;
                clear  = 1'b0;
                nbeats = k;
                return;
            end
            rdy = ($urandom_range(99) < ready_pct);
            pix_ready = rdy;
            @(posedge clock); #1;
            cyc++;
            if (rdy) k++;
        end
        nbeats = k;
    endtask

    task automatic main_seq();
        int n;
        resetb    = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        mode      = 2'd0;
        pix_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_valid", pix_valid, 0);
        check_eq("rst_data", pix_data, 0);
        check_eq("rst_sof", sof, 0);
        check_eq("rst_eol", eol, 0);
        check_eq("rst_eof", eof, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fc", frame_count, 0);
        resetb = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pix_ready = 1'($urandom_range(1));
            mode      = 2'($urandom_range(3));
            @(posedge clock); #1;
            check_eq("idle_valid", pix_valid, 0);
        end

        // Solid red, single enable pulse
        start_frame(2'd0, 1'b0);
        stream_frame(0, 100, -1, 1'b0, 2'd0, -1, n);
        check_eq("solid_beats", n, FRAME);
        check_eq("solid_valid_after", pix_valid, 0);
        check_eq("solid_busy_after", busy, 0);
        check_eq("solid_fc", frame_count, 1);
        repeat (5) @(posedge clock);
        #1;
        check_eq("solid_idle", pix_valid, 0);

        // Horizontal gradient under random backpressure
        start_frame(2'd1, 1'b0);
        stream_frame(1, 75, -1, 1'b0, 2'd0, -1, n);
        check_eq("grad_beats", n, FRAME);
        check_eq("grad_busy_after", busy, 0);
        check_eq("grad_fc", frame_count, 2);

        // Back-to-back: vertical gradient, then checker selected mid-frame
        start_frame(2'd2, 1'b1);
        stream_frame(2, 100, 3000, 1'b1, 2'd3, -1, n);
        check_eq("b2b_beats1", n, FRAME);
        check_eq("b2b_fc1", frame_count, 3);
        check_eq("b2b_busy_gap", busy, 1);
        stream_frame(3, 100, 10, 1'b0, 2'd3, -1, n);
        check_eq("b2b_beats2", n, FRAME);
        check_eq("b2b_fc2", frame_count, 4);
        check_eq("b2b_busy_after", busy, 0);

        // Abort with clear coinciding with a transfer
        start_frame(2'd0, 1'b0);
        stream_frame(0, 90, -1, 1'b0, 2'd0, 5000, n);
        check_eq("abort_beat", n, 5000);
        check_eq("abort_valid", pix_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_sof", sof, 0);
        check_eq("abort_eol", eol, 0);
        check_eq("abort_eof", eof, 0);
        check_eq("abort_fc", frame_count, 4);
        @(posedge clock); #1;
        check_eq("abort_stays_idle", pix_valid, 0);
        start_frame(2'd3, 1'b0);
        stream_frame(3, 100, -1, 1'b0, 2'd0, 40, n);
        check_eq("restart_fc", frame_count, 4);

        // Asynchronous reset mid-frame
        start_frame(2'd1, 1'b1);
        pix_ready = 1'b1;
        repeat (10) @(posedge clock);
        #2;
        resetb = 1'b0;
        #1;
        check_eq("areset_valid", pix_valid, 0);
        check_eq("areset_busy", busy, 0);
        check_eq("areset_data", pix_data, 0);
        check_eq("areset_fc", frame_count, 0);
        enable = 1'b0;
        @(posedge clock); #1;
        resetb = 1'b1;
    endtask

    task automatic wrap_seq();
        int cyc;
        w_resetb = 1'b0;
        w_en     = 1'b0;
        w_clear  = 1'b0;
        w_mode   = 2'($urandom_range(3));
        w_ready  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        w_resetb = 1'b1;
        w_en     = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            cyc = 0;
            while (!(w_valid && w_eof) && cyc < 3000) begin
                @(posedge clock); #1;
                cyc++;
            end
            check_eq("wrap_no_timeout", (cyc < 3000), 1);
            w_en = (f < 5);
            @(posedge clock); #1;
            check_eq("wrap_fc", w_fc, f % 4);
        end
        check_eq("wrap_busy_after", w_busy, 0);
    endtask

    initial begin
        fork
            main_seq();
            wrap_seq();
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
